prog_mem_loader: RTL and testbench

- Instruction-side counterpart of the processor control unit: it answers the fetch address `Addr` with the 16-bit instruction word `Data`.
- Before the CPU runs, it fills its program RAM from a byte stream delivered by the UART receiver (one `rx_done` pulse per byte).
- It holds the CPU stopped until a complete, valid program has been loaded, then serves fetches combinationally.

---
 rtl/prog_mem_loader_pkg.sv | 20 ++
 rtl/prog_mem_loader_if.sv | 28 ++
 rtl/prog_mem_loader_instr_ram.sv | 21 ++
 rtl/prog_mem_loader.sv | 132 +++++++++++++
 tb/tb_prog_mem_loader.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/prog_mem_loader_pkg.sv
// Shared types and defaults for the program-memory loader: FSM encoding,
// halt opcode and default bus widths.
package prog_loader_pkg;

    localparam int LEN_DATA_DEF = 16;
    localparam int LEN_ADDR_DEF = 11;
    localparam int LEN_BYTE_DEF = 8;

    localparam logic [4:0] OPCODE_HLT = 5'b00000;

    typedef enum logic [2:0] {
        S_CNT_LO  = 3'd0,
        S_CNT_HI  = 3'd1,
        S_DATA_LO = 3'd2,
        S_DATA_HI = 3'd3,
        S_RUN     = 3'd4,
        S_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// UART byte stream in, CPU fetch port and loader status out.
// master = UART/CPU side, slave = loader.
interface prog_mem_loader_if
    import prog_loader_pkg::*;
#(
    parameter int len_data = LEN_DATA_DEF,
    parameter int len_addr = LEN_ADDR_DEF,
    parameter int len_byte = LEN_BYTE_DEF
);
    logic [len_byte-1:0] rx_data;
    logic                rx_done;
    logic [len_addr-1:0] Addr;
    logic [len_data-1:0] Data;
    logic                cpu_run;
    logic                load_busy;
    logic                load_error;
    logic [len_addr:0]   word_count;

    modport master (
        output rx_data, rx_done, Addr,
        input  Data, cpu_run, load_busy, load_error, word_count
    );

    modport slave (
        input  rx_data, rx_done, Addr,
        output Data, cpu_run, load_busy, load_error, word_count
    );
endinterface

// File: rtl/prog_mem_loader_instr_ram.sv
// Program RAM: one clocked write port, asynchronous read port, no reset.
// Read latency 0; write lands on the rising edge with we=1.
module instr_ram #(
    parameter int len_data = 16,
    parameter int len_addr = 11
) (
    input  logic                clk,
    input  logic                we,
    input  logic [len_addr-1:0] waddr,
    input  logic [len_data-1:0] wdata,
    input  logic [len_addr-1:0] raddr,
    output logic [len_data-1:0] rdata
);
    logic [len_data-1:0] mem [0:(2**len_addr)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_mem_loader.sv
// Loads a little-endian UART program image (N, then N words) into RAM, then serves fetches.
// Fetch latency 0; no backpressure (one byte per rx_done). Optional inter-byte timeout: PROG_LOADER_TIMEOUT_EN.
module prog_mem_loader
    import prog_loader_pkg::*;
#(
    parameter int len_data       = LEN_DATA_DEF,
    parameter int len_addr       = LEN_ADDR_DEF,
    parameter int len_byte       = LEN_BYTE_DEF,
    parameter int ram_depth      = 2048,
    parameter int timeout_cycles = 50000
) (
    input  logic              clk,
    input  logic              reset,
    prog_mem_loader_if.slave  bus
);
    localparam int                  HDR_W    = 2 * len_byte;
    localparam logic [HDR_W-1:0]    DEPTH_N  = HDR_W'(ram_depth);
    localparam logic [len_data-1:0] HLT_WORD = {OPCODE_HLT, {(len_data-5){1'b0}}};

    state_t              state;
    logic [len_byte-1:0] lo_latch;
    logic [len_addr-1:0] wr_ptr;
    logic [len_addr:0]   word_count_q;
    logic                cpu_run_q;
    logic                busy_q;
    logic                err_q;

    logic [HDR_W-1:0]    hdr_n;
    logic                hdr_bad;
    logic                last_word;
    logic                ram_we;
    logic [len_data-1:0] ram_rdata;
    logic                tmo_hit;

    always_comb begin
        hdr_n     = {bus.rx_data, lo_latch};
        hdr_bad   = (hdr_n == '0) || (hdr_n > DEPTH_N);
        last_word = ({1'b0, wr_ptr} == (word_count_q - 1'b1));
        ram_we    = (state == S_DATA_HI) && bus.rx_done;
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(timeout_cycles + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_load;

    always_comb begin
        in_load = (state == S_CNT_HI) || (state == S_DATA_LO) || (state == S_DATA_HI);
        tmo_hit = in_load && !bus.rx_done && (tmo_cnt == TMO_W'(timeout_cycles));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    tmo_cnt <= '0;
        else if (bus.rx_done || !in_load || tmo_hit)   tmo_cnt <= '0;
        else                                           tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_CNT_LO;
            lo_latch     <= '0;
            wr_ptr       <= '0;
            word_count_q <= '0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (tmo_hit) begin
            // Abandoned stream: wait for a fresh header, not an error.
            state        <= S_CNT_LO;
            wr_ptr       <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
        end else if (bus.rx_done) begin
            case (state)
                S_CNT_LO: begin
                    lo_latch <= bus.rx_data;
                    busy_q   <= 1'b1;
                    state    <= S_CNT_HI;
                end
                S_CNT_HI: begin
                    if (hdr_bad) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_ERR;
                    end else begin
                        word_count_q <= (len_addr+1)'(hdr_n);
                        wr_ptr       <= '0;
                        state        <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    lo_latch <= bus.rx_data;
                    state    <= S_DATA_HI;
                end
                S_DATA_HI: begin
                    if (last_word) begin
                        cpu_run_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_RUN;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= S_DATA_LO;
                    end
                end
                default: ;
            endcase
        end
    end

    instr_ram #(
        .len_data (len_data),
        .len_addr (len_addr)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata ({bus.rx_data, lo_latch}),
        .raddr (bus.Addr),
        .rdata (ram_rdata)
    );

    // Anything outside the loaded image reads as HLT so a runaway PC stops cleanly.
    assign bus.Data = (cpu_run_q && ({1'b0, bus.Addr} < word_count_q)) ? ram_rdata : HLT_WORD;

    assign bus.cpu_run    = cpu_run_q;
    assign bus.load_busy  = busy_q;
    assign bus.load_error = err_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader; expectations are hand-computed per stream.
module tb_prog_mem_loader;
    import prog_loader_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    prog_mem_loader_if #(.len_data(16), .len_addr(11), .len_byte(8)) bus ();

    prog_mem_loader #(
        .len_data(16), .len_addr(11), .len_byte(8),
        .ram_depth(2048), .timeout_cycles(100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [10:0] a, input logic [15:0] exp);
        bus.Addr = a;
        #1;
        check_eq(tag, 32'(bus.Data), 32'(exp));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq({tag, "_rst_run"},  32'(bus.cpu_run),    32'd0);
        check_eq({tag, "_rst_busy"}, 32'(bus.load_busy),  32'd0);
        check_eq({tag, "_rst_err"},  32'(bus.load_error), 32'd0);
        check_eq({tag, "_rst_wc"},   32'(bus.word_count), 32'd0);
        rd({tag, "_rst_data"}, 11'd0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] load1 [0:6];
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        bus.rx_data  = '0;
        bus.rx_done  = 1'b0;
        bus.Addr     = '0;
        load1 = '{8'h03, 8'h00, 8'h01, 8'h08, 8'h02, 8'h10, 8'h03};

        // Normal load: N=3, words 0801 1002 1803
        do_reset("init");
        send_byte(load1[0]);
        check_eq("norm_busy_hdr", 32'(bus.load_busy), 32'd1);
        for (int i = 1; i < 7; i++) send_byte(load1[i]);
        check_eq("norm_wc", 32'(bus.word_count), 32'd3);
        @(negedge clk);
        bus.rx_data = 8'h18;
        bus.rx_done = 1'b1;
        #1;
        check_eq("norm_run_pre", 32'(bus.cpu_run), 32'd0);
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        check_eq("norm_run_post",  32'(bus.cpu_run),   32'd1);
        check_eq("norm_busy_post", 32'(bus.load_busy), 32'd0);
        rd("norm_a0", 11'd0, 16'h0801);
        rd("norm_a1", 11'd1, 16'h1002);
        rd("norm_a2", 11'd2, 16'h1803);
        rd("norm_a3", 11'd3, 16'h0000);
        rd("norm_a2047", 11'd2047, 16'h0000);

        // Zero header, trailing bytes ignored
        do_reset("zero");
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("zero_err",  32'(bus.load_error), 32'd1);
        check_eq("zero_busy", 32'(bus.load_busy),  32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check_eq("zero_err2", 32'(bus.load_error), 32'd1);
        check_eq("zero_run",  32'(bus.cpu_run),    32'd0);
        check_eq("zero_st",   32'(dut.state),      32'(S_ERR));
        rd("zero_a0", 11'd0, 16'h0000);
        rd("zero_a1", 11'd1, 16'h0000);

        // Oversize header N=2049
        do_reset("over");
        send_byte(8'h01);
        send_byte(8'h08);
        check_eq("over_err", 32'(bus.load_error), 32'd1);
        check_eq("over_wc",  32'(bus.word_count), 32'd0);
        check_eq("over_st",  32'(dut.state),      32'(S_ERR));

        // Largest legal header N=2048 is accepted
        do_reset("max");
        send_byte(8'h00);
        send_byte(8'h08);
        check_eq("max_err",  32'(bus.load_error), 32'd0);
        check_eq("max_busy", 32'(bus.load_busy),  32'd1);
        check_eq("max_wc",   32'(bus.word_count), 32'd2048);
        check_eq("max_st",   32'(dut.state),      32'(S_DATA_LO));

        // Reset mid-load, then reload N=1 word 1234
        do_reset("mid0");
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h77);
        do_reset("mid");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h12);
        check_eq("mid_run", 32'(bus.cpu_run),    32'd1);
        check_eq("mid_wc",  32'(bus.word_count), 32'd1);
        rd("mid_a0", 11'd0, 16'h1234);
        rd("mid_a1", 11'd1, 16'h0000);

        // Post-load bytes must not disturb RAM or status
        do_reset("post");
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        for (int i = 0; i < 10; i++) send_byte(8'hF0 + 8'(i));
        rd("post_a0", 11'd0, 16'h5678);
        check_eq("post_run",  32'(bus.cpu_run),   32'd1);
        check_eq("post_busy", 32'(bus.load_busy), 32'd0);
        check_eq("post_wc",   32'(bus.word_count), 32'd1);

        // Inter-byte gap of 101 cycles
        do_reset("tmo");
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        repeat (101) @(posedge clk);
        #1;
`ifdef PROG_LOADER_TIMEOUT_EN
        check_eq("tmo_gap_busy", 32'(bus.load_busy), 32'd0);
        check_eq("tmo_gap_wc",   32'(bus.word_count), 32'd0);
        check_eq("tmo_gap_err",  32'(bus.load_error), 32'd0);
`else
        check_eq("tmo_gap_busy", 32'(bus.load_busy), 32'd1);
`endif
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hCD);
        send_byte(8'hAB);
        check_eq("tmo_run", 32'(bus.cpu_run), 32'd1);
`ifdef PROG_LOADER_TIMEOUT_EN
        check_eq("tmo_wc", 32'(bus.word_count), 32'd1);
        rd("tmo_a0", 11'd0, 16'hABCD);
        rd("tmo_a1", 11'd1, 16'h0000);
`else
        check_eq("tmo_wc", 32'(bus.word_count), 32'd2);
        rd("tmo_a0", 11'd0, 16'h0111);
        rd("tmo_a1", 11'd1, 16'hCD00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
